// File: rtl/nic_input_arbiter_pkg.sv
// Shared register defines and arbiter state encoding for the NIC input arbiter.
package nic_input_arbiter_pkg;

    localparam int UDP_REG_ADDR_WIDTH = 23;
    localparam int ARB_REG_ADDR_WIDTH = 2;

    localparam logic [UDP_REG_ADDR_WIDTH-ARB_REG_ADDR_WIDTH-1:0] ARB_BLOCK_ADDR = 21'h000100;
    localparam logic [ARB_REG_ADDR_WIDTH-1:0] ARB_NUM_PKTS_SENT = 2'd0;
    localparam logic [ARB_REG_ADDR_WIDTH-1:0] ARB_LAST_QUEUE    = 2'd1;
    localparam logic [31:0] ARB_BAD_ADDR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HDRS,
        ARB_PKT
    } arb_state_t;

endpackage

// File: rtl/small_fifo.sv
// Small synchronous FIFO with fall-through head word and a nearly-full flag.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2,
    parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty,
    input  logic             clk,
    input  logic             reset
);

    localparam int DEPTH = 2**MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

    assign dout        = mem[rd_ptr];
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(NEARLY_FULL));

endmodule

// File: rtl/nic_input_arbiter.sv
// Packet-granular round-robin arbiter over per-queue FIFOs, with a
// packet counter and last-grant register on the UDP register ring.
module nic_input_arbiter
    import nic_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int NUM_QUEUES        = 8,
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int FIFO_DEPTH_BITS   = 2
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
    input  logic [NUM_QUEUES-1:0]              in_wr,
    output logic [NUM_QUEUES-1:0]              in_rdy,

    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,

    input  logic                               reg_req_in,
    input  logic                               reg_ack_in,
    input  logic                               reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
    input  logic [31:0]                        reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]       reg_src_in,

    output logic                               reg_req_out,
    output logic                               reg_ack_out,
    output logic                               reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
    output logic [31:0]                        reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]       reg_src_out
);

    localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int FW = CTRL_WIDTH + DATA_WIDTH;

    logic [NUM_QUEUES-1:0] fifo_empty;
    logic [NUM_QUEUES-1:0] fifo_nearly_full;
    logic [NUM_QUEUES-1:0] fifo_rd;
    logic [FW-1:0]         fifo_dout [NUM_QUEUES];

    arb_state_t      state;
    logic [QW-1:0]   cur_q;
    logic [QW-1:0]   last_grant;
    logic [31:0]     pkt_count;

    logic            grant_found;
    logic [QW-1:0]   grant_q;
    logic [FW-1:0]   head;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic            rd_en;
    logic            eop;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        small_fifo #(
            .WIDTH          (FW),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS),
            .NEARLY_FULL    (2**FIFO_DEPTH_BITS - 1)
        ) u_fifo (
            .din         ({in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH], in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en       (in_wr[g]),
            .rd_en       (fifo_rd[g]),
            .dout        (fifo_dout[g]),
            .nearly_full (fifo_nearly_full[g]),
            .empty       (fifo_empty[g]),
            .clk         (clk),
            .reset       (reset)
        );
    end

    assign in_rdy = ~fifo_nearly_full;

    // Scan starts one past the last granted queue so service rotates fairly.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_q     = '0;
        for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
            idx = (32'(last_grant) + i) % NUM_QUEUES;
            if (!grant_found && !fifo_empty[idx]) begin
                grant_found = 1'b1;
                grant_q     = QW'(idx);
            end
        end
    end

    always_comb begin
        head      = fifo_dout[cur_q];
        head_ctrl = head[FW-1 -: CTRL_WIDTH];
        rd_en     = (state != ARB_IDLE) && !fifo_empty[cur_q] && out_rdy;
        eop       = rd_en && (state == ARB_PKT) && (head_ctrl != '0);
        fifo_rd   = '0;
        if (rd_en) begin
            fifo_rd[cur_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            cur_q      <= '0;
            last_grant <= QW'(NUM_QUEUES-1);
            out_wr     <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
        end else begin
            out_wr <= rd_en;
            if (rd_en) begin
                out_data <= head[DATA_WIDTH-1:0];
                out_ctrl <= head_ctrl;
            end
            case (state)
                ARB_IDLE: begin
                    if (grant_found) begin
                        cur_q <= grant_q;
                        state <= ARB_HDRS;
                    end
                end
                ARB_HDRS: begin
                    if (rd_en && head_ctrl == '0) begin
                        state <= ARB_PKT;
                    end
                end
                ARB_PKT: begin
                    if (eop) begin
                        last_grant <= cur_q;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    logic                          tag_hit;
    logic [ARB_REG_ADDR_WIDTH-1:0] reg_off;
    logic                          cnt_wr;

    assign tag_hit = (reg_addr_in[UDP_REG_ADDR_WIDTH-1:ARB_REG_ADDR_WIDTH] == ARB_BLOCK_ADDR);
    assign reg_off = reg_addr_in[ARB_REG_ADDR_WIDTH-1:0];
    assign cnt_wr  = reg_req_in && tag_hit && !reg_rd_wr_L_in && (reg_off == ARB_NUM_PKTS_SENT);

    // A software write to the counter wins over a same-cycle EOP increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b1;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
            pkt_count       <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_src_out     <= reg_src_in;
            if (reg_req_in && tag_hit) begin
                reg_ack_out <= 1'b1;
                case (reg_off)
                    ARB_NUM_PKTS_SENT: reg_data_out <= reg_rd_wr_L_in ? pkt_count : reg_data_in;
                    ARB_LAST_QUEUE:    reg_data_out <= 32'(last_grant);
                    default:           reg_data_out <= ARB_BAD_ADDR_DATA;
                endcase
            end else begin
                reg_ack_out  <= reg_ack_in;
                reg_data_out <= reg_data_in;
            end
            if (cnt_wr) begin
                pkt_count <= reg_data_in;
            end else if (eop) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_nic_input_arbiter.sv
// Directed self-checking bench for nic_input_arbiter: packet ordering,
// back-pressure, register ring and mid-packet reset.
module tb_nic_input_arbiter;
    import nic_input_arbiter_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 8;
    localparam int SW = 2;
    localparam int FW = CW + DW;
    localparam int AW = UDP_REG_ADDR_WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [NQ*DW-1:0]  in_data;
    logic [NQ*CW-1:0]  in_ctrl;
    logic [NQ-1:0]     in_wr;
    logic [NQ-1:0]     in_rdy;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy = 1'b1;
    logic              reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [AW-1:0]     reg_addr_in;
    logic [31:0]       reg_data_in;
    logic [SW-1:0]     reg_src_in;
    logic              reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [AW-1:0]     reg_addr_out;
    logic [31:0]       reg_data_out;
    logic [SW-1:0]     reg_src_out;

    always #5 clk = ~clk;

    nic_input_arbiter #(
        .DATA_WIDTH        (DW),
        .CTRL_WIDTH        (CW),
        .NUM_QUEUES        (NQ),
        .UDP_REG_SRC_WIDTH (SW),
        .FIFO_DEPTH_BITS   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .in_rdy          (in_rdy),
        .out_data        (out_data),
        .out_ctrl        (out_ctrl),
        .out_wr          (out_wr),
        .out_rdy         (out_rdy),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out)
    );

    int          checks = 0;
    int          errors = 0;
    int          rdy_viol = 0;
    logic        rdy_edge = 1'b1;
    bit          rnd_rdy = 1'b0;
    logic [FW-1:0] src_q [NQ][$];
    logic [FW-1:0] got_q [$];
    logic [FW-1:0] exp_q [$];

    // Word tag: ctrl FF = module header, 00 = payload, 10 = EOP.
    function automatic logic [FW-1:0] mkword(int q, int p, int w);
        logic [7:0] c;
        c = (w == 0) ? 8'hFF : (w == 5) ? 8'h10 : 8'h00;
        return {c, 32'hA5A50000, 8'(q), 8'(p), 16'(w)};
    endfunction

    function automatic logic [AW-1:0] arb_addr(int off);
        return {ARB_BLOCK_ADDR, ARB_REG_ADDR_WIDTH'(off)};
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_pkt(int q, int p);
        for (int w = 0; w < 6; w++) src_q[q].push_back(mkword(q, p, w));
    endtask

    task automatic expect_pkt(int q, int p);
        for (int w = 0; w < 6; w++) exp_q.push_back(mkword(q, p, w));
    endtask

    task automatic wait_words(int n, int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic compare_out(input string tag);
        repeat (10) @(negedge clk);
        chk({tag, "_count"}, FW'(got_q.size()), FW'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic reg_rw(input logic rdwr_l, input logic [AW-1:0] a, input logic [31:0] wd);
        @(negedge clk);
        reg_req_in     = 1'b1;
        reg_ack_in     = 1'b0;
        reg_rd_wr_L_in = rdwr_l;
        reg_addr_in    = a;
        reg_data_in    = wd;
        reg_src_in     = 2'd1;
        @(negedge clk);
        reg_req_in     = 1'b0;
        reg_data_in    = '0;
    endtask

    always @(posedge clk) rdy_edge <= out_rdy;

    always @(negedge clk) begin
        if (out_wr === 1'b1) begin
            got_q.push_back({out_ctrl, out_data});
            if (!rdy_edge) rdy_viol++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Source model: one word per queue per cycle while the queue shows ready.
    initial begin
        logic [FW-1:0] w;
        in_wr   = '0;
        in_data = '0;
        in_ctrl = '0;
        forever begin
            @(negedge clk);
            for (int q = 0; q < NQ; q++) begin
                if (src_q[q].size() > 0 && in_rdy[q] === 1'b1 && reset === 1'b0) begin
                    w = src_q[q].pop_front();
                    in_data[q*DW +: DW] = w[DW-1:0];
                    in_ctrl[q*CW +: CW] = w[FW-1:DW];
                    in_wr[q] = 1'b1;
                end else begin
                    in_wr[q] = 1'b0;
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        reg_req_in     = 1'b0;
        reg_ack_in     = 1'b0;
        reg_rd_wr_L_in = 1'b1;
        reg_addr_in    = '0;
        reg_data_in    = '0;
        reg_src_in     = '0;
        repeat (3) @(negedge clk);

        chk("rst_out_wr",  FW'(out_wr), FW'(0));
        chk("rst_req_out", FW'(reg_req_out), FW'(0));
        chk("rst_ack_out", FW'(reg_ack_out), FW'(0));
        chk("rst_data_out", FW'(reg_data_out), FW'(0));
        chk("rst_in_rdy",  FW'(in_rdy), FW'(8'hFF));
        reset = 1'b0;

        reg_rw(1'b1, arb_addr(0), '0);
        chk("rst_cnt_ack", FW'(reg_ack_out), FW'(1));
        chk("rst_cnt",     FW'(reg_data_out), FW'(0));
        reg_rw(1'b1, arb_addr(1), '0);
        chk("rst_lastq",   FW'(reg_data_out), FW'(7));

        // Queues 0 and 3, one packet each.
        load_pkt(0, 0); load_pkt(3, 0);
        expect_pkt(0, 0); expect_pkt(3, 0);
        wait_words(12, 500);
        compare_out("two_q");
        reg_rw(1'b1, arb_addr(0), '0);
        chk("two_q_cnt",   FW'(reg_data_out), FW'(2));
        reg_rw(1'b1, arb_addr(1), '0);
        chk("two_q_lastq", FW'(reg_data_out), FW'(3));

        // All queues loaded with two packets each.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int q = 0; q < NQ; q++) begin
                load_pkt(q, r);
                expect_pkt(q, r);
            end
        end
        wait_words(96, 3000);
        compare_out("all_q");
        reg_rw(1'b1, arb_addr(1), '0);
        chk("all_q_lastq", FW'(reg_data_out), FW'(7));
        reg_rw(1'b1, arb_addr(0), '0);
        chk("all_q_cnt",   FW'(reg_data_out), FW'(16));

        // Random back-pressure.
        rnd_rdy = 1'b1;
        load_pkt(1, 2); load_pkt(6, 2);
        expect_pkt(1, 2); expect_pkt(6, 2);
        wait_words(12, 3000);
        rnd_rdy = 1'b0;
        compare_out("bp");
        chk("bp_rdy_viol", FW'(rdy_viol), FW'(0));

        // Register ring: invalid offset and foreign tag.
        reg_rw(1'b1, arb_addr(2), '0);
        chk("bad_off_ack",  FW'(reg_ack_out), FW'(1));
        chk("bad_off_data", FW'(reg_data_out), FW'(32'hDEADBEEF));
        reg_rw(1'b1, {21'h001234, 2'd0}, 32'h12345678);
        chk("foreign_data", FW'(reg_data_out), FW'(32'h12345678));
        chk("foreign_ack",  FW'(reg_ack_out), FW'(0));
        chk("foreign_req",  FW'(reg_req_out), FW'(1));
        chk("foreign_addr", FW'(reg_addr_out), FW'({21'h001234, 2'd0}));

        // Counter wrap.
        reg_rw(1'b0, arb_addr(0), 32'hFFFFFFFF);
        chk("wr_cnt_ack", FW'(reg_ack_out), FW'(1));
        load_pkt(4, 3);
        expect_pkt(4, 3);
        wait_words(6, 500);
        compare_out("wrap");
        reg_rw(1'b1, arb_addr(0), '0);
        chk("wrap_cnt", FW'(reg_data_out), FW'(0));

        // Reset mid-packet on queue 5, then a clean packet on queue 2.
        load_pkt(5, 4);
        wait_words(2, 500);
        chk("q5_started", FW'(got_q.size() >= 2), FW'(1));
        @(negedge clk);
        reset = 1'b1;
        src_q[5].delete();
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        load_pkt(2, 5);
        expect_pkt(2, 5);
        wait_words(6, 500);
        compare_out("rst_mid");
        reg_rw(1'b1, arb_addr(1), '0);
        chk("rst_mid_lastq", FW'(reg_data_out), FW'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
